// File: rtl/pipe_perf_monitor_pkg.sv
// Shared types and constants for the pipeline performance monitor.
// Covers the run-state encoding and the counter overflow modes.
package pipe_perf_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/perf_counter.sv
// Single performance counter with a sticky overflow flag.
// Past all-ones it either wraps to zero or holds at all-ones.
module perf_counter
    import pipe_perf_monitor_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int SAT   = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    logic [CNT_W-1:0] value_reg;
    logic             ovf_reg;
    logic             at_max;

    assign at_max = &value_reg;

    // clr outranks inc, so a same-cycle event is dropped and the counter ends at 0
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (inc) begin
            if (at_max) begin
                ovf_reg   <= 1'b1;
                value_reg <= (SAT == MODE_SAT) ? value_reg : '0;
            end else begin
                value_reg <= value_reg + CNT_W'(1);
            end
        end
    end

    assign value = value_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Counts qualified pipeline events and run cycles, stops at an optional
// cycle limit, and exposes the counters through a snapshot/select read port.
module pipe_perf_monitor
    import pipe_perf_monitor_pkg::*;
#(
    parameter int N_EV    = 4,
    parameter int CNT_W   = 32,
    parameter int SAT     = MODE_WRAP,
    parameter int MAX_CYC = 0,
    localparam int SEL_W  = $clog2(N_EV + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [N_EV-1:0]  event_i,
    input  logic             snap_i,
    input  logic [SEL_W-1:0] rd_sel_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [CNT_W-1:0] cycle_o,
    output logic [N_EV:0]    ovf_o,
    output logic             done_o,
    output logic             running_o
);

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_CYC - 1);

    state_t           state_reg;
    state_t           state_next;
    logic             in_run;
    logic             limit_hit;
    logic [N_EV:0]    inc;
    logic [N_EV:0]    ovf;
    logic [CNT_W-1:0] live [N_EV+1];
    logic [CNT_W-1:0] shadow_reg [N_EV+1];
    logic [CNT_W-1:0] rd_data_reg;

    assign in_run = (state_reg == ST_RUN);

    // Index N_EV is the cycle counter; it advances on every RUN cycle
    generate
        for (genvar gi = 0; gi < N_EV; gi++) begin : g_ev_inc
            assign inc[gi] = in_run && event_i[gi];
        end
    endgenerate
    assign inc[N_EV] = in_run;

    generate
        for (genvar gi = 0; gi <= N_EV; gi++) begin : g_cnt
            perf_counter #(
                .CNT_W (CNT_W),
                .SAT   (SAT)
            ) u_cnt (
                .clk   (clk_i),
                .rst   (rst_i),
                .clr   (clear_i),
                .inc   (inc[gi]),
                .value (live[gi]),
                .ovf   (ovf[gi])
            );
        end
    endgenerate

    // The limit is reached in the RUN cycle whose increment lands on MAX_CYC
    assign limit_hit = (MAX_CYC != 0) && in_run && (live[N_EV] == LIMIT_M1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_i && !clear_i) state_next = ST_RUN;
            ST_RUN: begin
                if (limit_hit && !clear_i) begin
                    state_next = ST_DONE;
                end else if (!start_i) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: if (clear_i) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        running_o = (state_reg == ST_RUN);
        done_o    = (state_reg == ST_DONE);
    end

    // Shadows take the registered live value, i.e. before this cycle's clear/increment
    generate
        for (genvar gi = 0; gi <= N_EV; gi++) begin : g_shadow
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    shadow_reg[gi] <= '0;
                end else if (snap_i) begin
                    shadow_reg[gi] <= live[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_reg <= '0;
        end else if (rd_sel_i <= SEL_W'(N_EV)) begin
            rd_data_reg <= shadow_reg[rd_sel_i];
        end else begin
            rd_data_reg <= '0;
        end
    end

    assign rd_data_o = rd_data_reg;
    assign cycle_o   = live[N_EV];
    assign ovf_o     = ovf;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench: four monitor configurations share one stimulus stream,
// each scenario checks the instance whose parameters it targets.
module tb_pipe_perf_monitor;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [1:0] event_i = '0;
    logic       snap_i = 1'b0;
    logic [1:0] rd_sel_i = '0;

    logic [31:0] a_rd, a_cyc, l_rd, l_cyc;
    logic [2:0]  a_ovf, l_ovf, w_ovf, s_ovf;
    logic        a_done, a_run, l_done, l_run, w_done, w_run, s_done, s_run;
    logic [3:0]  w_rd, w_cyc, s_rd, s_cyc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_perf_monitor #(.N_EV(2), .CNT_W(32), .SAT(0), .MAX_CYC(0)) u_a (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .event_i(event_i), .snap_i(snap_i), .rd_sel_i(rd_sel_i),
        .rd_data_o(a_rd), .cycle_o(a_cyc), .ovf_o(a_ovf),
        .done_o(a_done), .running_o(a_run));

    pipe_perf_monitor #(.N_EV(2), .CNT_W(32), .SAT(0), .MAX_CYC(10)) u_l (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .event_i(event_i), .snap_i(snap_i), .rd_sel_i(rd_sel_i),
        .rd_data_o(l_rd), .cycle_o(l_cyc), .ovf_o(l_ovf),
        .done_o(l_done), .running_o(l_run));

    pipe_perf_monitor #(.N_EV(2), .CNT_W(4), .SAT(0), .MAX_CYC(0)) u_w (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .event_i(event_i), .snap_i(snap_i), .rd_sel_i(rd_sel_i),
        .rd_data_o(w_rd), .cycle_o(w_cyc), .ovf_o(w_ovf),
        .done_o(w_done), .running_o(w_run));

    pipe_perf_monitor #(.N_EV(2), .CNT_W(4), .SAT(1), .MAX_CYC(0)) u_s (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .event_i(event_i), .snap_i(snap_i), .rd_sel_i(rd_sel_i),
        .rd_data_o(s_rd), .cycle_o(s_cyc), .ovf_o(s_ovf),
        .done_o(s_done), .running_o(s_run));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic read_a(input logic [1:0] sel, input string tag, input logic [31:0] exp);
        rd_sel_i = sel;
        tick();
        check_val(tag, a_rd, exp);
    endtask

    initial begin
        // reset
        tick();
        tick();
        check_val("rst_rd", a_rd, 0);
        check_val("rst_cycle", a_cyc, 0);
        check_val("rst_ovf", a_ovf, 0);
        check_val("rst_done", a_done, 0);
        check_val("rst_running", a_run, 0);
        rst_i = 1'b0;
        tick();
        check_val("idle_running", a_run, 0);

        // basic count: RUN cycles at edges 1..8, ev1 on odd edges
        for (int i = 0; i <= 8; i++) begin
            start_i = (i < 8);
            event_i = {1'(i % 2 == 1), 1'b1};
            tick();
        end
        start_i = 1'b0;
        event_i = '0;
        snap_i  = 1'b1;
        tick();
        snap_i = 1'b0;
        read_a(2'd0, "basic_ev0", 8);
        read_a(2'd1, "basic_ev1", 4);
        read_a(2'd2, "basic_cycle", 8);
        read_a(2'd3, "basic_sel_oob", 0);
        check_val("basic_ovf", a_ovf, 0);

        // cycle limit 10 on u_l
        do_clear();
        for (int i = 0; i < 20; i++) begin
            start_i = 1'b1;
            event_i = 2'b01;
            tick();
            if (i == 9) begin
                check_val("lim_done_e9", l_done, 0);
                check_val("lim_cycle_e9", l_cyc, 9);
            end
            if (i == 10) begin
                check_val("lim_done_e10", l_done, 1);
                check_val("lim_cycle_e10", l_cyc, 10);
            end
        end
        check_val("lim_cycle_hold", l_cyc, 10);
        check_val("lim_done_hold", l_done, 1);
        check_val("lim_running", l_run, 0);
        start_i = 1'b0;
        event_i = '0;
        snap_i  = 1'b1;
        tick();
        snap_i   = 1'b0;
        rd_sel_i = 2'd0;
        tick();
        check_val("lim_ev0", l_rd, 10);
        do_clear();
        check_val("lim_clr_done", l_done, 0);
        check_val("lim_clr_cycle", l_cyc, 0);
        snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
        tick();
        check_val("lim_clr_ev0", l_rd, 0);

        // 17 events into 4-bit counters: wrap vs saturate
        for (int i = 0; i <= 17; i++) begin
            start_i = 1'b1;
            event_i = {1'b0, 1'(i >= 1)};
            tick();
        end
        start_i = 1'b0;
        event_i = '0;
        tick();
        snap_i = 1'b1;
        tick();
        snap_i   = 1'b0;
        rd_sel_i = 2'd0;
        tick();
        check_val("wrap_ev0", w_rd, 1);
        check_val("wrap_ovf0", w_ovf[0], 1);
        check_val("sat_ev0", s_rd, 15);
        check_val("sat_ovf0", s_ovf[0], 1);

        // pause: start 1x3, 0x5, 1x2, events continuous
        do_clear();
        for (int i = 0; i <= 10; i++) begin
            start_i = (i < 3) || (i == 8) || (i == 9);
            event_i = 2'b01;
            tick();
            check_val($sformatf("pause_running_e%0d", i), a_run,
                      ((i < 3) || (i == 8) || (i == 9)) ? 1 : 0);
        end
        event_i = '0;
        check_val("pause_cycle", a_cyc, 5);
        snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
        read_a(2'd0, "pause_ev0", 5);

        // clear + snap + event together at live count 6
        do_clear();
        for (int i = 0; i <= 6; i++) begin
            start_i = 1'b1;
            event_i = {1'b0, 1'(i >= 1)};
            tick();
        end
        clear_i  = 1'b1;
        snap_i   = 1'b1;
        start_i  = 1'b0;
        event_i  = 2'b01;
        rd_sel_i = 2'd0;
        tick();
        check_val("simul_old_shadow", a_rd, 5);
        check_val("simul_live_cycle", a_cyc, 0);
        check_val("simul_ovf", a_ovf, 0);
        clear_i = 1'b0;
        snap_i  = 1'b0;
        event_i = '0;
        tick();
        check_val("simul_shadow_ev0", a_rd, 6);
        snap_i = 1'b1;
        tick();
        snap_i = 1'b0;
        tick();
        check_val("simul_live_ev0", a_rd, 0);

        // reset pulse while running
        snap_i = 1'b1;
        tick();
        snap_i  = 1'b0;
        start_i = 1'b1;
        event_i = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        check_val("rstrun_pre_running", a_run, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_val("rstrun_running", a_run, 0);
        check_val("rstrun_cycle", a_cyc, 0);
        check_val("rstrun_rd", a_rd, 0);
        check_val("rstrun_ovf", a_ovf, 0);
        check_val("rstrun_done", a_done, 0);
        tick();
        check_val("rstrun_restart", a_run, 1);
        start_i = 1'b0;
        event_i = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

Synthesizable, parametrised performance-counter block for the pipelined CPU. It replaces ad-hoc stall/flush counting and fixed cycle-limit stopping in simulation with in-design counters. It counts N_EV qualified pipeline event strobes (stall, flush, retire, …) plus run cycles, and stops at a programmable cycle limit. Counters are read through a snapshot-and-select port, so a bench or debug path can sample them without racing the live counters.

## Interface
Parameters:
- N_EV, 4: number of event channels.
- CNT_W, 32: width of every counter, including the cycle counter.
- SAT, 0: 0 means counters wrap modulo 2^CNT_W; 1 means counters saturate at all-ones.
- MAX_CYC, 0: cycle limit for the run; 0 means unlimited. Must fit in CNT_W.
- SEL_W (local), $clog2(N_EV+1): width of the read-select index.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  level run-enable.
- clear_i  in  1  synchronous clear of all counters, overflow flags and the done state.
- event_i  in  N_EV  per-channel event strobe, already qualified (e.g. stall && !branch).
- snap_i  in  1  copies all live counters into shadow registers.
- rd_sel_i  in  SEL_W  read index: 0..N_EV-1 selects an event shadow; N_EV selects the cycle shadow.
- rd_data_o  out  CNT_W  registered read data.
- cycle_o  out  CNT_W  live cycle count.
- ovf_o  out  N_EV+1  sticky overflow flags; bit N_EV belongs to the cycle counter.
- done_o  out  1  high while in DONE.
- running_o  out  1  high while in RUN.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE to RUN: start_i=1 and clear_i=0.
- RUN to IDLE: start_i=0. This is a pause; counters hold their values.
- RUN to DONE: MAX_CYC≠0 and the cycle counter increments to MAX_CYC.
- DONE to IDLE: clear_i=1. DONE ignores start_i.
- In RUN, each cycle:
  - The cycle counter increments by 1.
  - Event counter k increments by 1 when event_i[k]=1.
- In IDLE and DONE, events are ignored and counters hold.
- The cycle in which the limit is reached is a RUN cycle, so its events are counted.
- Wrap mode (SAT=0): all-ones + 1 gives 0 and sets ovf[k].
- Saturate mode (SAT=1): all-ones + 1 stays at all-ones and sets ovf[k].
- Overflow flags are sticky; only clear_i or rst_i clears them.
- Snapshot: snap_i=1 loads each shadow with the registered live value, i.e. the value before this cycle's increment.
- Read: rd_data_o is the shadow selected by rd_sel_i, registered. An index greater than N_EV returns 0.
- Priority, highest first: rst_i, clear_i, count.
  - clear_i together with an event: the counter ends at 0.
  - clear_i together with snap_i: the shadows capture the pre-clear values; the live counters go to 0.
- start_i and clear_i together in IDLE: clear only; the FSM stays in IDLE.

## Timing
- Reset values: rd_data_o=0, cycle_o=0, ovf_o=0, done_o=0, running_o=0; all shadows=0; state=IDLE.
- running_o and done_o are decoded from registered state, so they change one cycle after the causing input is sampled.
- Counter update: an event sampled at edge t appears in the live counter after edge t. It is visible in a shadow after a snap_i sampled at edge t+1 or later.
- Read latency: rd_sel_i sampled at edge t gives rd_data_o valid after edge t.
- A snap_i at edge t and a read at edge t+1 return the new snapshot. A read at edge t returns the old shadow.
- MAX_CYC=3 with start_i held from edge 0:
  - RUN is entered after edge 0.
  - cycle_o reaches 3 after edge 3; done_o=1 from that edge on.
  - cycle_o stays at 3 thereafter.

## Structure
- pipe_perf_monitor_pkg: the state enum (ST_IDLE, ST_RUN, ST_DONE) and the mode constants MODE_WRAP=0 and MODE_SAT=1.
- Sub-module perf_counter: one CNT_W counter with an SAT parameter, inputs inc/clr, and outputs value/ovf. It is instantiated N_EV+1 times: N_EV event channels plus the cycle counter, whose inc is the RUN state.
- The top level holds the FSM, the shadow array and the read mux/register.

## Test plan
- Basic count. N_EV=2, MAX_CYC=0; start_i high for 8 cycles; event_i[0] every cycle, event_i[1] every other cycle; then snap, then read sel 0, 1, 2. Required: 8, 4, 8, and ovf_o=0.
- Limit. MAX_CYC=10, start_i held for 20 cycles with event_i[0]=1 throughout. Required: done_o=1 after edge 10; cycle_o=10; event 0 count=10; no further counting; clear_i returns the block to IDLE with all counters 0.
- Wrap vs saturate. CNT_W=4; 17 events on channel 0.
  - SAT=0: count=1, ovf_o[0]=1.
  - SAT=1: count=15, ovf_o[0]=1.
- Pause. start_i 1 for 3 cycles, 0 for 5, 1 for 2, with events continuous. Required: cycle count=5, event count=5, running_o low only during the gap.
- Simultaneous events. clear_i, snap_i and event_i[0] together while the live count is 6. Required: shadow=6, live=0, ovf cleared. Next-cycle read returns 6.
- Reset mid-run. rst_i pulsed for 1 cycle while in RUN. Required: all outputs 0 and state IDLE after the edge. Because start_i is still held, running_o=1 one cycle after rst_i falls.
